// File: rtl/gate_op_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gate_op_arbiter
//  Brief    : Round-robin time-sharing of one 1-bit NOT/OR/AND/XOR evaluator
//             among N_REQ requesters with a req/gnt/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module gate_op_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] op,
    input  logic [N_REQ-1:0]   a,
    input  logic [N_REQ-1:0]   b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               y,
    output logic               busy
);

    localparam int C_PW = $clog2(N_REQ);
    localparam int C_CW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_EXEC = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    generate
        if (LAT < 1) begin : g_lat_check
            $error("gate_op_arbiter: LAT must be at least 1");
        end
        if ((N_REQ < 2) || (N_REQ > 8)) begin : g_nreq_check
            $error("gate_op_arbiter: N_REQ must be in 2..8");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [C_PW-1:0]  r_ptr;
    logic [C_CW-1:0]  r_cnt;
    logic [1:0]       r_op;
    logic             r_a;
    logic             r_b;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic             r_y;

    logic             w_found;
    logic [C_PW-1:0]  w_winner;
    logic [1:0]       w_op;
    logic             w_a;
    logic             w_b;
    logic             w_result;

    // Scan from the slot after the last winner; only the winner's operands
    // are selected, so unused requesters' inputs cannot reach the datapath.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_op     = 2'b00;
        w_a      = 1'b0;
        w_b      = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % N_REQ]) begin
                w_found  = 1'b1;
                w_winner = C_PW'((int'(r_ptr) + k) % N_REQ);
                w_op     = op[2*((int'(r_ptr) + k) % N_REQ) +: 2];
                w_a      = a[(int'(r_ptr) + k) % N_REQ];
                w_b      = b[(int'(r_ptr) + k) % N_REQ];
            end
        end
    end

    always_comb begin
        case (r_op)
            2'b00:   w_result = ~r_a;
            2'b01:   w_result = r_a | r_b;
            2'b10:   w_result = r_a & r_b;
            default: w_result = r_a ^ r_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_ptr   <= C_PW'(N_REQ - 1);
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_y     <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                C_ST_IDLE: begin
                    if (w_found) begin
                        r_ptr   <= w_winner;
                        r_op    <= w_op;
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_gnt   <= N_REQ'(1) << w_winner;
                        r_cnt   <= C_CW'(LAT - 1);
                        r_state <= C_ST_EXEC;
                    end
                end
                C_ST_EXEC: begin
                    if (r_cnt == '0) begin
                        r_y     <= w_result;
                        r_done  <= N_REQ'(1) << r_ptr;
                        r_state <= C_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                C_ST_DONE: begin
                    r_state <= C_ST_IDLE;
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign y    = r_y;
    assign busy = (r_state == C_ST_EXEC) || (r_state == C_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gate_op_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_op_arbiter
//  Brief    : Self-checking bench for gate_op_arbiter (LAT=1 and LAT=3 copies
//             driven by the same stimulus, each against a reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gate_op_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [2*N-1:0] op;
    logic [N-1:0] a;
    logic [N-1:0] b;

    logic [N-1:0] gnt1, done1, gnt3, done3;
    logic         y1, busy1, y3, busy3;

    int n_tests = 0;
    int n_fail  = 0;

    // Truth table indexed by {opcode, a, b}
    logic [15:0] tt = 16'b0110_1000_1110_0011;

    // Reference model state, index 0 -> LAT=1 copy, index 1 -> LAT=3 copy
    bit       m_active [2];
    int       m_age    [2];
    int       m_w      [2];
    int       m_ptr    [2];
    logic     m_res    [2];
    logic [N-1:0] e_gnt  [2];
    logic [N-1:0] e_done [2];
    logic     e_y      [2];
    logic     e_busy   [2];

    gate_op_arbiter #(.N_REQ(N), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt1), .done(done1), .y(y1), .busy(busy1)
    );

    gate_op_arbiter #(.N_REQ(N), .LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt3), .done(done3), .y(y3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: an op granted at edge k completes at edge k+LAT, the unit is
    // free again after edge k+LAT+1 and arbitrates at the following edge.
    task automatic model_step(input int i);
        int lat;
        int w;
        lat = (i == 0) ? 1 : 3;
        if (rst) begin
            m_active[i] = 0;
            m_ptr[i]    = N - 1;
            e_gnt[i]    = '0;
            e_done[i]   = '0;
            e_y[i]      = 1'b0;
            e_busy[i]   = 1'b0;
        end else if (m_active[i]) begin
            m_age[i]++;
            e_gnt[i]  = '0;
            e_done[i] = '0;
            e_busy[i] = 1'b1;
            if (m_age[i] == lat) begin
                e_done[i] = N'(1) << m_w[i];
                e_y[i]    = m_res[i];
            end else if (m_age[i] == lat + 1) begin
                e_busy[i]   = 1'b0;
                m_active[i] = 0;
            end
        end else begin
            e_done[i] = '0;
            e_gnt[i]  = '0;
            e_busy[i] = 1'b0;
            w = -1;
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && req[(m_ptr[i] + k) % N]) w = (m_ptr[i] + k) % N;
            end
            if (w >= 0) begin
                m_w[i]      = w;
                m_ptr[i]    = w;
                m_active[i] = 1;
                m_age[i]    = 0;
                m_res[i]    = tt[{op[2*w +: 2], a[w], b[w]}];
                e_gnt[i]    = N'(1) << w;
                e_busy[i]   = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [2*N-1:0] o,
                        input logic [N-1:0] aa, input logic [N-1:0] bb);
        rst = r; req = rq; op = o; a = aa; b = bb;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("gnt_lat1",  8'(gnt1),  8'(e_gnt[0]));
        check("done_lat1", 8'(done1), 8'(e_done[0]));
        check("y_lat1",    8'(y1),    8'(e_y[0]));
        check("busy_lat1", 8'(busy1), 8'(e_busy[0]));
        check("gnt_lat3",  8'(gnt3),  8'(e_gnt[1]));
        check("done_lat3", 8'(done3), 8'(e_done[1]));
        check("y_lat3",    8'(y3),    8'(e_y[1]));
        check("busy_lat3", 8'(busy3), 8'(e_busy[1]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [N-1:0] order [$];
        logic [3:0]   combo;

        // Reset with every requester active
        step(1'b1, 4'b1111, 8'hFF, 4'hF, 4'hF);
        step(1'b1, 4'b1111, 8'hFF, 4'hF, 4'hF);
        check("rst_gnt", 8'(gnt1 | gnt3), 8'h00);

        // Single op on requester 2: OR 0|0, then NOT 0
        step(1'b0, 4'b0100, 8'b00_01_00_00, 4'b0000, 4'b0000);
        check("single_gnt", 8'(gnt1), 8'h04);
        step(1'b0, 4'b0000, 8'h00, 4'h0, 4'h0);
        check("single_done", 8'(done1), 8'h04);
        check("single_y_or", 8'(y1), 8'h00);
        idle(4);
        step(1'b0, 4'b0100, 8'b00_00_00_00, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 8'h00, 4'h0, 4'h0);
        check("single_y_not", 8'(y1), 8'h01);
        idle(4);

        // Round-robin from reset with all requesters active
        step(1'b1, 4'b0000, 8'h00, 4'h0, 4'h0);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 4'b1111, 8'($urandom), 4'($urandom), 4'($urandom));
            if (gnt1 != '0) order.push_back(gnt1);
        end
        for (int k = 0; k < 8; k++) check("rr_order", 8'(order[k]), 8'(1 << (k % 4)));
        idle(5);

        // Full opcode table on requester 1
        for (int c = 0; c < 16; c++) begin
            combo = 4'(c);
            step(1'b0, 4'b0010, {4'b0000, combo[3:2], 2'b00}, {2'b00, combo[1], 1'b0},
                 {2'b00, combo[0], 1'b0});
            step(1'b0, 4'b0000, 8'h00, 4'h0, 4'h0);
            check("optable_y", 8'(y1), 8'(tt[combo]));
            idle(4);
        end

        // LAT=3 with operands changed and req dropped after the grant
        step(1'b0, 4'b0001, 8'b00_00_00_01, 4'b0001, 4'b0000);
        check("midop_gnt", 8'(gnt3), 8'h01);
        step(1'b0, 4'b0000, 8'b00_00_00_11, 4'b0000, 4'b0001);
        step(1'b0, 4'b0000, 8'b00_00_00_11, 4'b0000, 4'b0001);
        step(1'b0, 4'b0000, 8'b00_00_00_11, 4'b0000, 4'b0001);
        check("midop_done", 8'(done3), 8'h01);
        check("midop_y", 8'(y3), 8'h01);
        idle(3);

        // Reset while the LAT=3 copy is executing
        step(1'b0, 4'b0100, 8'b00_11_00_00, 4'b0100, 4'b0000);
        step(1'b0, 4'b0000, 8'h00, 4'h0, 4'h0);
        step(1'b1, 4'b0000, 8'h00, 4'h0, 4'h0);
        idle(4);
        check("rstmid_nodone", 8'(done3), 8'h00);
        step(1'b0, 4'b1001, 8'h00, 4'h0, 4'h0);
        check("rstmid_gnt", 8'(gnt3), 8'h01);
        idle(5);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 4'($urandom), 8'($urandom),
                 4'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
